tb_obi_mem: RTL and testbench

Behavioural single-port OBI memory slave for the core-level testbench. It sits directly downstream of the core's instruction or data OBI port: it consumes req/addr/we/be/wdata and produces gnt/rvalid/rdata. The bench instantiates one for instructions (writes unused) and one for data. Grant stalls and response latency are configurable, so the core's fetch and LSU handshakes can be exercised beyond the zero-wait case.

---
 rtl/tb_obi_mem.sv | 118 +++++++++++
 tb/tb_tb_obi_mem.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tb_obi_mem.sv
// Behavioural single-port OBI memory slave with configurable grant throttling
// and fixed response latency, used as instruction/data memory in core benches.
module tb_obi_mem #(
    parameter int unsigned MEM_WORDS       = 16384,
    parameter int unsigned RESP_LAT        = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        stall_i
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic [31:0]         mem_q [MEM_WORDS];
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                acc;
    logic                in_range;
    logic [AW-1:0]       idx;
    resp_t               resp_in;
    logic [RESP_LAT-1:0] vld_pipe;
    resp_t               dat_pipe [RESP_LAT];
    logic                last_v;
    resp_t               last_in;
    logic                unused_addr;

    assign unused_addr = ^addr_i[1:0];

    // Grant looks only at the registered count, so a response retiring this
    // cycle cannot open a slot for this cycle's request.
    assign gnt_o    = req_i & ~stall_i & (cnt_q < CW'(MAX_OUTSTANDING));
    assign acc      = req_i & gnt_o;
    assign idx      = addr_i[AW+1:2];
    assign in_range = (addr_i[31:AW+2] == '0);

    always_comb begin
        resp_in.err   = ~in_range;
        resp_in.rdata = (we_i || !in_range) ? 32'h0 : mem_q[idx];
    end

    // Array deliberately has no reset.
    always_ff @(posedge clk_i) begin
        if (acc && we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({acc, rvalid_o})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    generate
        if (RESP_LAT == 1) begin : g_lat1
            assign last_v  = acc;
            assign last_in = resp_in;
        end else begin : g_latn
            assign last_v  = vld_pipe[RESP_LAT-2];
            assign last_in = dat_pipe[RESP_LAT-2];
        end
    endgenerate

    // Final stage only loads on a valid entry, which gives the hold-last-value
    // behaviour of rdata_o/err_o for free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            for (int k = 0; k < int'(RESP_LAT); k++) dat_pipe[k] <= '0;
        end else begin
            vld_pipe[0] <= acc;
            for (int k = 1; k < int'(RESP_LAT); k++) vld_pipe[k] <= vld_pipe[k-1];
            if (RESP_LAT > 1) dat_pipe[0] <= resp_in;
            for (int k = 1; k < int'(RESP_LAT) - 1; k++) dat_pipe[k] <= dat_pipe[k-1];
            if (last_v) dat_pipe[RESP_LAT-1] <= last_in;
        end
    end

    assign rvalid_o = vld_pipe[RESP_LAT-1];
    assign rdata_o  = dat_pipe[RESP_LAT-1].rdata;
    assign err_o    = dat_pipe[RESP_LAT-1].err;

`ifndef SYNTHESIS
    a_req_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown(req_i));
    a_obi_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> (req_i && $stable(addr_i) && $stable(we_i) &&
                               $stable(be_i) && $stable(wdata_i)));
    a_cnt_over : assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CW'(MAX_OUTSTANDING));
    a_cnt_under : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rvalid_o && cnt_q == '0));
`endif
endmodule

// File: tb/tb_tb_obi_mem.sv
// Bench for tb_obi_mem: two instances (latency 1 and 3) checked every cycle
// against a transaction-level model of memory contents and response timing.
module tb_tb_obi_mem;
    localparam int MAXO = 2;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, gnt, we, stall, rvalid, err;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [3:0]  be [2];

    logic [31:0] mm [0:1][0:16383];
    exp_t        exq [2][$];
    logic [31:0] last_rd [2];
    logic        last_err [2];
    logic        g_obs [2];
    logic [31:0] pat;
    int          cyc, total, passed;

    always #5 clk = ~clk;

    tb_obi_mem #(.MEM_WORDS(16384), .RESP_LAT(1), .MAX_OUTSTANDING(MAXO)) u_d0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]),
        .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]), .stall_i(stall[0]));

    tb_obi_mem #(.MEM_WORDS(16384), .RESP_LAT(3), .MAX_OUTSTANDING(MAXO)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]),
        .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]), .stall_i(stall[1]));

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] fillv(int i);
        return 32'hA5A5_0000 | (i * 32'h0101);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic accept(int d);
        logic [13:0] idx;
        logic        inr;
        exp_t        e;
        idx   = addr[d][15:2];
        inr   = (addr[d][31:16] == 16'h0);
        e.due = cyc + lat(d);
        e.err = !inr;
        e.rd  = (!we[d] && inr) ? mm[d][idx] : 32'h0;
        if (we[d] && inr)
            for (int b = 0; b < 4; b++)
                if (be[d][b]) mm[d][idx][8*b +: 8] = wdata[d][8*b +: 8];
        exq[d].push_back(e);
    endtask

    // One clock: check grant, response and held data at the negedge, then
    // record any accept into the model.
    task automatic step();
        logic eg, erv;
        exp_t e;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            eg  = req[d] && !stall[d] && (exq[d].size() < MAXO);
            chk($sformatf("d%0d gnt", d), gnt[d], eg);
            erv = (exq[d].size() > 0) && (exq[d][0].due == cyc);
            chk($sformatf("d%0d rvalid", d), rvalid[d], erv);
            if (erv) begin
                e = exq[d].pop_front();
                last_rd[d]  = e.rd;
                last_err[d] = e.err;
            end
            chk($sformatf("d%0d rdata", d), rdata[d], last_rd[d]);
            chk($sformatf("d%0d err", d), err[d], last_err[d]);
            g_obs[d] = gnt[d];
            if (req[d] && gnt[d]) accept(d);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int d, logic w, logic [31:0] a, logic [3:0] b, logic [31:0] wd);
        int n;
        n = 0;
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        do begin
            step();
            pat = {pat[30:0], g_obs[d]};
            n++;
        end while (!g_obs[d] && n < 20);
        if (!g_obs[d]) chk($sformatf("d%0d grant timeout", d), g_obs[d], 1);
    endtask

    task automatic idle(int n);
        req = '0;
        stall = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; passed = 0; cyc = 0; pat = '0;
        rst_n = 1'b0; req = '0; we = '0; stall = '0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wdata[d] = '0; be[d] = '0;
            last_rd[d] = '0; last_err[d] = 1'b0; g_obs[d] = 1'b0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset rvalid", d), rvalid[d], 0);
            chk($sformatf("d%0d reset rdata", d), rdata[d], 0);
            chk($sformatf("d%0d reset err", d), err[d], 0);
            chk($sformatf("d%0d reset gnt idle", d), gnt[d], 0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // known contents for words 0..15 in both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) issue(d, 1'b1, i * 4, 4'hF, fillv(i));
            idle(4);
        end

        // write then read back-to-back, latency 1
        issue(0, 1'b1, 32'h100, 4'hF, 32'hCAFEBABE);
        issue(0, 1'b0, 32'h100, 4'hF, 32'h0);
        idle(3);
        chk("t1 read data", rdata[0], 32'hCAFEBABE);
        chk("t1 read err", err[0], 0);

        // byte enables
        issue(0, 1'b1, 32'h200, 4'hF, 32'h11223344);
        issue(0, 1'b1, 32'h200, 4'b0101, 32'hAABBCCDD);
        issue(0, 1'b0, 32'h200, 4'hF, 32'h0);
        idle(3);
        chk("t2 merged data", rdata[0], 32'h11BB33DD);

        // throttling with latency 3, two outstanding
        pat = '0;
        for (int i = 0; i < 5; i++) issue(1, 1'b0, i * 4, 4'hF, 32'h0);
        chk("t3 gnt pattern", pat[8:0], 9'b110011001);
        idle(6);
        chk("t3 last read data", rdata[1], fillv(4));

        // stall suppresses grant only
        stall[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h8; be[0] = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4 stalled gnt", g_obs[0], 0);
        end
        stall[0] = 1'b0;
        step();
        chk("t4 gnt after stall", g_obs[0], 1);
        idle(3);
        chk("t4 read data", rdata[0], fillv(2));

        // out of range
        issue(0, 1'b0, 32'h0001_0000, 4'hF, 32'h0);
        idle(3);
        chk("t5 oor rdata", rdata[0], 0);
        chk("t5 oor err", err[0], 1);
        issue(0, 1'b1, 32'h0001_0000, 4'hF, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h0, 4'hF, 32'h0);
        idle(3);
        chk("t5 word0 unchanged", rdata[0], fillv(0));
        chk("t5 word0 err", err[0], 0);

        // reset with two reads in flight
        issue(1, 1'b0, 32'h4, 4'hF, 32'h0);
        issue(1, 1'b0, 32'h8, 4'hF, 32'h0);
        req = '0;
        rst_n = 1'b0;
        #1;
        chk("t6 rvalid in reset", rvalid[1], 0);
        chk("t6 rdata in reset", rdata[1], 0);
        for (int d = 0; d < 2; d++) begin
            exq[d].delete();
            last_rd[d] = '0;
            last_err[d] = 1'b0;
        end
        @(negedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
        idle(6);
        issue(1, 1'b0, 32'hC, 4'hF, 32'h0);
        idle(4);
        chk("t6 read after reset", rdata[1], fillv(3));

        // randomized traffic, holding requests stable until granted
        for (int c = 0; c < 300; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!(req[d] && !g_obs[d])) begin
                    int w;
                    w        = $urandom_range(0, 15);
                    req[d]   = ($urandom_range(0, 9) < 7);
                    we[d]    = 1'($urandom_range(0, 1));
                    be[d]    = 4'($urandom);
                    wdata[d] = $urandom;
                    addr[d]  = (w << 2) | $urandom_range(0, 3);
                    if ($urandom_range(0, 7) == 0)
                        addr[d] = addr[d] | (32'h0001_0000 << $urandom_range(0, 15));
                end
                stall[d] = ($urandom_range(0, 4) == 0);
            end
            step();
        end
        idle(6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
